// File: rtl/usrt_tx_ctrl_if.sv
// Host-side byte handshake for the USRT transmit controller: data, parity mode
// and a valid/ready pair. The host drives the master modport.
interface usrt_tx_ctrl_if;
  logic       i_Valid;
  logic [7:0] i_Data;
  logic [1:0] i_Parity;
  logic       o_Ready;

  modport master (output i_Valid, output i_Data, output i_Parity, input o_Ready);
  modport slave  (input i_Valid, input i_Data, input i_Parity, output o_Ready);
endinterface

// File: rtl/usrt_tx_ctrl.sv
// USRT transmit controller: one-entry holding buffer feeding a framing FSM that
// shifts start, 8 data bits (LSB first), optional parity and stop onto o_Tx.
module usrt_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           i_Pclk,
  input  logic           i_Reset,
  usrt_tx_ctrl_if.slave  host,
  output logic           o_Tx,
  output logic           o_Busy,
  output logic           o_Done
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          buf_full_q;
  logic [7:0]    buf_data_q;
  logic [1:0]    buf_mode_q;
  logic          tx_d, busy_d, done_d;
  logic          accept, load, bit_end;

  assign host.o_Ready = !buf_full_q;
  assign accept       = host.i_Valid && !buf_full_q;
  assign bit_end      = (baud_q == BAUD_LAST);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    load      = 1'b0;
    state_d   = state_q;
    baud_d    = bit_end ? '0 : baud_q + CW'(1);
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (buf_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Refill straight into START so back-to-back frames have no idle gap.
        if (bit_end) begin
          if (buf_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      baud_d    = '0;
      bit_d     = 3'd0;
      shreg_d   = buf_data_q;
      par_en_d  = (buf_mode_q == 2'b01) || (buf_mode_q == 2'b10);
      par_bit_d = (buf_mode_q == 2'b10) ? ~^buf_data_q : ^buf_data_q;
    end

    // Outputs are registered, so derive them from the next state.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'd0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      buf_full_q <= 1'b0;
      o_Tx       <= 1'b1;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      o_Tx       <= tx_d;
      o_Busy     <= busy_d;
      o_Done     <= done_d;
      if (load)        buf_full_q <= 1'b0;
      else if (accept) buf_full_q <= 1'b1;
    end
  end

  // NOTE: buffer payload needs no reset; it is only read while buf_full_q is
  // set, and that flag is reset.
  always_ff @(posedge i_Pclk) begin
    if (accept) begin
      buf_data_q <= host.i_Data;
      buf_mode_q <= host.i_Parity;
    end
  end

endmodule

// File: doc/usrt_tx_ctrl.md
# usrt_tx_ctrl

Transmit controller for the USRT serial path. Accepts bytes over a valid/ready handshake into a one-entry holding buffer, frames each byte (start bit, 8 data bits LSB first, optional parity bit, stop bit) and shifts it out on `o_Tx` at a fixed bit period. It sits between the host-side byte interface and the serial pin, sequencing framing and bit timing for back-to-back transfers.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥1. Counter width is `$clog2(CLKS_PER_BIT)`, minimum 1.
- `i_Pclk` in 1: the single clock. All logic is on the rising edge.
- `i_Reset` in 1: reset, synchronous and active-high.
- `i_Parity` in 2: parity mode, sampled with the byte at acceptance.
  - 2'b00: no parity bit.
  - 2'b01: even parity.
  - 2'b10: odd parity.
  - 2'b11: no parity bit (same as 2'b00).
- `i_Valid` in 1: `i_Data` and `i_Parity` hold a byte to send.
- `i_Data` in 8: byte to transmit.
- `o_Ready` out 1: holding buffer empty; a byte can be accepted this cycle.
- `o_Tx` out 1: serial line; idles at 1.
- `o_Busy` out 1: a frame is being shifted (FSM not in IDLE).
- `o_Done` out 1: one-cycle pulse at the end of each stop bit.

## Operation
- **Holding buffer:** one entry storing `{parity mode, data}`, plus a full flag.
  - `o_Ready = !buf_full`, combinational from the flag.
  - A byte is accepted on any edge with `i_Valid && o_Ready`; the flag is set on that edge.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `o_Tx`=1. If `buf_full`, load the shift register, bit counter and mode from the buffer, clear `buf_full`, go to START.
  - START: `o_Tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `o_Tx = shreg[0]`. Each bit lasts `CLKS_PER_BIT` cycles, then the register shifts right. After bit index 7, go to PARITY if the mode is 01 or 10, else go to STOP.
  - PARITY: `o_Tx = ^data` for even parity, `~^data` for odd parity, held `CLKS_PER_BIT` cycles. Parity is computed over the latched byte. Then go to STOP.
  - STOP: `o_Tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle, pulse `o_Done`. If `buf_full`, load from the buffer and go directly to START (no idle gap); else go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 within each bit and resets to 0 on every bit or state change.
- **Bit counter:** 3 bits, indexing data bits 0..7.
- **Buffer load vs. accept:** a load from the buffer and a new accept cannot occur on the same edge, because `o_Ready` is low while the buffer is full. The buffer refills from the first cycle after it is drained.
- **`o_Busy`:** 1 in every state except IDLE.
- **Outputs are registered:** `o_Tx`, `o_Busy` and `o_Done` are registered; `o_Ready` is the only combinational output.
- **Reset:** takes priority over everything.
  - Reset values: FSM=IDLE, `buf_full`=0, counters=0, `o_Tx`=1, `o_Busy`=0, `o_Done`=0, `o_Ready`=1.
  - Reset mid-frame aborts the frame and discards the buffered byte. `o_Tx` is 1 after the reset edge, and no `o_Done` pulse is produced.
- **Parity modes:** modes 00 and 11 give a 10-bit frame; modes 01 and 10 give an 11-bit frame.

## Timing
- **Accept to start bit:** accept at edge k. `buf_full`=1 after k. The FSM loads at edge k+1, so `o_Tx` falls and `o_Busy` rises after k+1. `o_Ready` returns to 1 after k+1.
- **Frame length:**
  - Without parity: 10·`CLKS_PER_BIT` cycles from the start-bit edge to the end of the stop bit.
  - With parity: 11·`CLKS_PER_BIT` cycles.
- **Back-to-back:** if the buffer is full at the last stop cycle, the next start bit begins on the following cycle, with zero idle cycles between frames.
- **`o_Done`:** high exactly one cycle, coincident with the last cycle of the stop bit.
- **Mode changes:** changes to `i_Parity` after acceptance have no effect on the in-flight or buffered frame.
- **`CLKS_PER_BIT`=1:** every bit is exactly one cycle, and all transitions still follow the rules above.

## Test plan
- **Reset values:** hold `i_Reset` 3 cycles, then release. Required: `o_Tx`=1, `o_Ready`=1, `o_Busy`=0, `o_Done`=0.
- **Even parity, single byte:** `CLKS_PER_BIT`=4, send 8'h03 with mode 01. Required: `o_Tx` sequence 0,1,1,0,0,0,0,0,0,0,1, each bit held 4 cycles (parity bit 0). The frame spans 44 cycles, `o_Done` pulses once, and the FSM returns to IDLE.
- **Odd parity and no parity:** send 8'h07 with mode 10. Required: parity bit 0 (3 ones, odd parity). Send 8'h07 with mode 00. Required: 10-bit frame of 40 cycles, with no parity bit.
- **Back-to-back with buffering:** send 8'hA5 then 8'h3C, holding `i_Valid` high. Required:
  - The second byte is accepted on the cycle after the first byte loads into the FSM.
  - `o_Ready` stays 0 until the second frame starts.
  - No idle cycle between stop and start.
  - Two `o_Done` pulses, 40 cycles apart (mode 00).
- **Reset mid-frame:** assert `i_Reset` during data bit 3, with a second byte buffered. Required: `o_Tx`=1 and `o_Busy`=0 after the reset edge, `o_Ready`=1, and no `o_Done`. No frame is transmitted afterwards until a new accept.
- **Stall:** hold `i_Valid`=0 for 20 cycles after a frame. Required: `o_Tx` stays 1, `o_Busy`=0, and `o_Ready`=1 throughout.
